// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the arbitrated multiplier.
package mult_arb_pkg;

    // Per-requester arithmetic interpretation of the operands.
    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arb_mul.sv
// Existing multiplier: PW-bit product of two sign/zero-extended N-bit operands.
// With PW = 2N the full product is produced; with PW = N only the low half.
module mult_arb_mul #(
    parameter int N  = 8,
    parameter int PW = 2 * N
) (
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          sgn,
    output logic [PW-1:0] p
);

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] hi_mask;

    // Extend operands to the product width; the upper fill is the sign bit in signed mode.
    always_comb begin
        hi_mask = ~PW'({N{1'b1}});
        a_ext   = PW'(a) | ((sgn && a[N-1]) ? hi_mask : '0);
        b_ext   = PW'(b) | ((sgn && b[N-1]) ? hi_mask : '0);
        p       = a_ext * b_ext;
    end

endmodule

// File: rtl/mult_rr_arb.sv
// Round-robin grant: first set request at or above ptr, wrapping NREQ-1 -> 0.
module mult_rr_arb
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]             req,
    input  logic [id_width(NREQ)-1:0]   ptr,
    output logic [NREQ-1:0]             grant
);

    localparam int IDW = id_width(NREQ);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    // Scan requesters in rotated order starting at ptr; grant only the first hit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum = {1'b0, ptr} + (IDW+1)'(off);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Multi-requester multiplier: round-robin arbitration onto one shared multiplier
// with a single-entry registered response. Optional overflow flag is enabled by
// defining MULT_ARB_OVF_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*N-1:0]           req_a,
    input  logic [NREQ*N-1:0]           req_b,
    input  logic [NREQ-1:0]             req_mode,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [id_width(NREQ)-1:0]   rsp_id,
    output logic [N-1:0]                rsp_p
`ifdef MULT_ARB_OVF_EN
    ,
    output logic                        rsp_ovf
`endif
);

    localparam int IDW = id_width(NREQ);
`ifdef MULT_ARB_OVF_EN
    localparam int PW = 2 * N;
`else
    localparam int PW = N;
`endif

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    logic            accept;
    logic            handshake;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    mode_e           op_mode;
    logic [PW-1:0]   prod;

    mult_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Output register can take a new product when empty or being drained this cycle.
    always_comb begin
        accept    = !rsp_valid || rsp_ready;
        req_ready = accept ? grant : '0;
        handshake = accept && (|grant);
    end

    // Encode the one-hot grant and steer the winner's operands to the multiplier.
    always_comb begin
        gid     = '0;
        op_a    = '0;
        op_b    = '0;
        op_mode = MODE_UNSIGNED;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gid     = IDW'(i);
                op_a    = req_a[i*N +: N];
                op_b    = req_b[i*N +: N];
                op_mode = mode_e'(req_mode[i]);
            end
        end
    end

    mult_arb_mul #(
        .N  (N),
        .PW (PW)
    ) u_mul (
        .a   (op_a),
        .b   (op_b),
        .sgn (op_mode == MODE_SIGNED),
        .p   (prod)
    );

`ifdef MULT_ARB_OVF_EN
    logic ovf_next;

    // Unsigned: any upper-half bit set. Signed: upper N+1 bits not a pure sign extension.
    always_comb begin
        if (op_mode == MODE_SIGNED) begin
            ovf_next = !((&prod[PW-1:N-1]) || !(|prod[PW-1:N-1]));
        end else begin
            ovf_next = |prod[PW-1:N];
        end
    end

    // Overflow flag travels with the product it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ovf <= 1'b0;
        end else if (handshake) begin
            rsp_ovf <= ovf_next;
        end
    end
`endif

    // Response register: load on a grant, clear valid when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else if (handshake) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gid;
            rsp_p     <= prod[N-1:0];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the requester that was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter (N=8, NREQ=4). Overflow checks are active
// when MULT_ARB_OVF_EN is defined.
module tb_mult_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_mode;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [N-1:0]      rsp_p;
`ifdef MULT_ARB_OVF_EN
    logic              rsp_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vm [5];
    logic [7:0] vp [5];
    logic       vo [5];

    mult_arbiter #(
        .N    (N),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
`ifdef MULT_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic m);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_mode[i]     = m;
    endtask

    initial begin
        // overflow vectors on requester 0: A, B, mode, expected product, expected ovf
        va[0] = 8'h10; vb[0] = 8'h10; vm[0] = 1'b0; vp[0] = 8'h00; vo[0] = 1'b1;
        va[1] = 8'h40; vb[1] = 8'h02; vm[1] = 1'b1; vp[1] = 8'h80; vo[1] = 1'b1;
        va[2] = 8'h05; vb[2] = 8'h03; vm[2] = 1'b0; vp[2] = 8'h0F; vo[2] = 1'b0;
        va[3] = 8'hFE; vb[3] = 8'hFE; vm[3] = 1'b1; vp[3] = 8'h04; vo[3] = 1'b0;
        va[4] = 8'hFE; vb[4] = 8'h03; vm[4] = 1'b1; vp[4] = 8'hFA; vo[4] = 1'b0;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_mode  = '0;
        rsp_ready = 1'b1;
        tick;
        tick;
        check_eq("reset_valid", rsp_valid, 0);
        check_eq("reset_id", rsp_id, 0);
        check_eq("reset_p", rsp_p, 0);
`ifdef MULT_ARB_OVF_EN
        check_eq("reset_ovf", rsp_ovf, 0);
`endif
        #2 rst_n = 1'b1;

        // single unsigned request on 0
        set_req(0, 8'h0F, 8'h03, 1'b0);
        req_valid = 4'b0001;
        #1 check_eq("r0_ready", req_ready, 4'b0001);
        tick;
        check_eq("r0_valid", rsp_valid, 1);
        check_eq("r0_id", rsp_id, 0);
        check_eq("r0_p", rsp_p, 8'h2D);
        req_valid = '0;
        #1 check_eq("idle_ready", req_ready, 0);
        tick;
        check_eq("drain_valid", rsp_valid, 0);

        // signed request on 2, ptr is 1 so search passes over 1
        set_req(2, 8'hFE, 8'h03, 1'b1);
        req_valid = 4'b0100;
        #1 check_eq("r2_ready", req_ready, 4'b0100);
        tick;
        check_eq("r2_valid", rsp_valid, 1);
        check_eq("r2_id", rsp_id, 2);
        check_eq("r2_p", rsp_p, 8'hFA);
`ifdef MULT_ARB_OVF_EN
        check_eq("r2_ovf", rsp_ovf, 0);
`endif
        req_valid = '0;
        tick;

        // reset back to ptr 0, then stream all four requesters
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'h10, 1'b0);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1 check_eq("rr_ready", req_ready, 4'b0001 << (k % 4));
            tick;
            check_eq("rr_valid", rsp_valid, 1);
            check_eq("rr_id", rsp_id, k % 4);
            check_eq("rr_p", rsp_p, ((k % 4) + 1) * 16);
        end

        // back-pressure: response held on id 1, nothing accepted
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check_eq("stall_ready", req_ready, 0);
            tick;
            check_eq("stall_valid", rsp_valid, 1);
            check_eq("stall_id", rsp_id, 1);
            check_eq("stall_p", rsp_p, 8'h20);
        end
        rsp_ready = 1'b1;
        #1 check_eq("resume_ready", req_ready, 4'b0100);
        tick;
        check_eq("resume_id", rsp_id, 2);
        check_eq("resume_p", rsp_p, 8'h30);

        // async reset mid-stream: ptr would be 3, reset returns search to 0
        req_valid = 4'b1010;
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", rsp_valid, 0);
        check_eq("mid_rst_id", rsp_id, 0);
        check_eq("mid_rst_p", rsp_p, 0);
        tick;
        rst_n = 1'b1;
        #1 check_eq("post_rst_ready", req_ready, 4'b0010);
        tick;
        check_eq("post_rst_valid", rsp_valid, 1);
        check_eq("post_rst_id", rsp_id, 1);
        check_eq("post_rst_p", rsp_p, 8'h20);

        // no requests: no grant and ptr (2) holds
        req_valid = '0;
        #1 check_eq("none_ready", req_ready, 0);
        tick;
        check_eq("none_valid", rsp_valid, 0);
        tick;
        tick;
        req_valid = 4'b1111;
        #1 check_eq("hold_ptr_ready", req_ready, 4'b0100);
        tick;
        check_eq("hold_ptr_id", rsp_id, 2);
        check_eq("hold_ptr_p", rsp_p, 8'h30);
        req_valid = '0;
        tick;

        // product / overflow vectors on requester 0 (search wraps from ptr)
        for (int v = 0; v < 5; v++) begin
            set_req(0, va[v], vb[v], vm[v]);
            req_valid = 4'b0001;
            tick;
            req_valid = '0;
            check_eq("vec_id", rsp_id, 0);
            check_eq("vec_p", rsp_p, vp[v]);
`ifdef MULT_ARB_OVF_EN
            check_eq("vec_ovf", rsp_ovf, vo[v]);
`endif
            tick;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand and product width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester request valid.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-requester accept.
REQ-007 The block SHALL have port req_a, input, NREQ*N bits: operand A; slice i belongs to requester i.
REQ-008 The block SHALL have port req_b, input, NREQ*N bits: operand B; slice i belongs to requester i.
REQ-009 The block SHALL have port req_mode, input, NREQ bits: 0 = unsigned, 1 = two's-complement signed.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: response valid.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-012 The block SHALL have port rsp_id, output, $clog2(NREQ) bits: index of the served requester.
REQ-013 The block SHALL have port rsp_p, output, N bits: product truncated to its low N bits.
REQ-014 The block SHALL have port rsp_ovf, output, 1 bit, present only with MULT_ARB_OVF_EN.

Function
REQ-015 Accept condition SHALL be: accept = !rsp_valid || rsp_ready (1-deep output register, no bubble under continuous rsp_ready).
REQ-016 On accept, the block SHALL grant exactly one valid requester, round-robin, searching from ptr upward with wrap NREQ-1 -> 0.
REQ-017 req_ready[i] SHALL be 1 iff i is granted and accept holds; req_ready is combinational from req_valid, ptr and the output state.
REQ-018 On a handshake with requester g, ptr SHALL become (g+1) mod NREQ; otherwise ptr SHALL hold.
REQ-019 Latency SHALL be 1: the cycle after a handshake, rsp_valid=1, rsp_id=g, and rsp_p = low N bits of A*B under req_mode[g].
REQ-020 When rsp_valid && !rsp_ready, rsp_id, rsp_p and rsp_ovf SHALL hold stable and all req_ready SHALL be 0.
REQ-021 When rsp_valid && rsp_ready with no new grant, rsp_valid SHALL drop to 0 the next cycle.
REQ-022 When rsp_valid && rsp_ready with a new grant in the same cycle, the response register SHALL reload (back-to-back).
REQ-023 With no req_valid bits set, the block SHALL grant nothing and ptr SHALL hold.
REQ-024 Throughput SHALL be one product per cycle while rsp_ready=1 and any req_valid=1.

Reset
REQ-025 While rst_n=0 the block SHALL force rsp_valid=0, rsp_id=0, rsp_p=0, rsp_ovf=0 and ptr=0, asynchronously.
REQ-026 Reset mid-operation SHALL discard any pending response; after release, the first grant SHALL search from requester 0.

Configuration
REQ-027 With macro MULT_ARB_OVF_EN defined, rsp_ovf SHALL be registered alongside rsp_p.
REQ-028 Unsigned overflow SHALL mean the upper N bits of the 2N-bit product are nonzero.
REQ-029 Signed overflow SHALL mean the upper N+1 bits of the 2N-bit product are not all equal.
REQ-030 Without MULT_ARB_OVF_EN, the rsp_ovf port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-031 Package mult_arb_pkg SHALL hold the mode enum (MODE_UNSIGNED=0, MODE_SIGNED=1) and the id-width helper function.
REQ-032 Round-robin grant and pointer logic SHALL live in sub-module mult_rr_arb (inputs: req vector, ptr; output: one-hot grant).
REQ-033 The datapath SHALL instantiate the team's existing multiplier once, fed through an NREQ:1 operand mux.

Verification (N=8, NREQ=4)
REQ-034 req0 A=0x0F B=0x03 mode=0 -> next cycle rsp_valid=1, rsp_id=0, rsp_p=0x2D.
REQ-035 req2 A=0xFE B=0x03 mode=1 -> rsp_id=2, rsp_p=0xFA.
REQ-036 All four requesters valid, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, with no idle cycle.
REQ-037 rsp_ready=0 for 3 cycles while rsp_valid=1 -> response fields frozen, req_ready=0, ptr unchanged.
REQ-038 rst_n pulsed low mid-stream -> rsp_valid=0 immediately; first post-reset grant goes to the lowest-index valid requester from 0.
REQ-039 With MULT_ARB_OVF_EN: A=0x10 B=0x10 mode=0 -> rsp_p=0x00, rsp_ovf=1; A=0x40 B=0x02 mode=1 -> rsp_p=0x80, rsp_ovf=1; A=0x05 B=0x03 -> rsp_ovf=0.
